// File: rtl/gouram_trace_if.sv
// gouram_trace_if: record input stream and timestamped output stream of the trace controller
interface gouram_trace_if #(
  parameter int TS_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int PAYLOAD_WIDTH = 64
);
  logic rec_valid;
  logic [ADDR_WIDTH-1:0] rec_addr;
  logic [PAYLOAD_WIDTH-1:0] rec_payload;
  logic out_valid;
  logic out_ready;
  logic [TS_WIDTH-1:0] out_ts;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [PAYLOAD_WIDTH-1:0] out_payload;
  modport master (output rec_valid, rec_addr, rec_payload, out_ready,
                  input out_valid, out_ts, out_addr, out_payload);
  modport slave (input rec_valid, rec_addr, rec_payload, out_ready,
                 output out_valid, out_ts, out_addr, out_payload);
endinterface

// File: rtl/gouram_trace_ctrl.sv
// gouram_trace_ctrl: armed trace capture with timestamped output FIFO, drop counting and lock
module gouram_trace_ctrl #(
  parameter int TS_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int REPEAT_THRESHOLD = 4,
  parameter int DROP_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  gouram_trace_if.slave bus,
  input  logic [1:0] cfg_mode,
  input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_stop_addr,
  input  logic arm,
  input  logic stop,
  input  logic clear_lock,
  output logic trace_capture_enable,
  output logic lock,
  output logic overflow,
  output logic [DROP_WIDTH-1:0] drop_count,
  output logic [TS_WIDTH-1:0] counter_o
);
  localparam int EW = TS_WIDTH + ADDR_WIDTH + PAYLOAD_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = PW + 1;
  localparam int RW = $clog2(REPEAT_THRESHOLD + 1);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [1:0] mode_q;
  logic [TS_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [RW-1:0] run_q, run_d;
  logic ovf_q;
  logic [DROP_WIDTH-1:0] drop_q;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [FW-1:0] fill_q;
  logic start, cap, push, pop, full, empty;
  assign start = state_q == IDLE && arm && !stop && !clear_lock;
  assign cap = bus.rec_valid && !stop &&
               (state_q == CAPTURE || (state_q == ARMED && bus.rec_addr == cfg_start_addr));
  assign full = fill_q == FW'(FIFO_DEPTH);
  assign empty = fill_q == '0;
  assign pop = !empty && bus.out_ready;
  assign push = cap && (!full || pop);
  assign bus.out_valid = !empty;
  assign {bus.out_ts, bus.out_addr, bus.out_payload} = empty ? '0 : mem_q[rd_q];
  assign trace_capture_enable = state_q == CAPTURE;
  assign lock = state_q == LOCKED;
  assign overflow = ovf_q;
  assign drop_count = drop_q;
  assign counter_o = cnt_q;
  // run_q == 0 marks "no record since arm", so the first capture always starts a fresh run
  assign run_d = (run_q == '0 || bus.rec_addr != last_q) ? RW'(1) :
                 (run_q == RW'(REPEAT_THRESHOLD)) ? run_q : run_q + 1'b1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (cfg_mode == 2'd1 ? ARMED : CAPTURE) : IDLE;
      ARMED:   state_d = stop ? IDLE : cap ? CAPTURE : ARMED;
      CAPTURE: state_d = stop ? IDLE :
                         (cap && mode_q == 2'd1 && bus.rec_addr == cfg_stop_addr) ? IDLE :
                         (cap && mode_q == 2'd2 && run_d == RW'(REPEAT_THRESHOLD)) ? LOCKED : CAPTURE;
      LOCKED:  state_d = clear_lock ? IDLE : LOCKED;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '1;
      mode_q <= '0;
      last_q <= '0;
      run_q <= '0;
      ovf_q <= 1'b0;
      drop_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      fill_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_q + 1'b1;
      if (start) begin
        mode_q <= cfg_mode;
        run_q <= '0;
        ovf_q <= 1'b0;
        drop_q <= '0;
      end else if (cap) begin
        last_q <= bus.rec_addr;
        run_q <= run_d;
      end
      if (cap && !push) begin
        ovf_q <= 1'b1;
        drop_q <= &drop_q ? drop_q : drop_q + 1'b1;
      end
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      fill_q <= fill_q + FW'(push) - FW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= {cnt_q, bus.rec_addr, bus.rec_payload};
endmodule

// File: tb/tb_gouram_trace_ctrl.sv
// tb_gouram_trace_ctrl: scoreboard bench for the trace capture controller
module tb_gouram_trace_ctrl;
  logic clk = 0, rst = 1;
  logic [1:0] cfg_mode = 0;
  logic [15:0] cfg_start_addr = 0, cfg_stop_addr = 0;
  logic arm = 0, stop = 0, clear_lock = 0;
  logic trace_capture_enable, lock, overflow;
  logic [15:0] drop_count;
  logic [31:0] counter_o;
  logic [31:0] exp_cnt = '1;
  logic [111:0] sb [$];
  int n_tests = 0, n_fail = 0;
  gouram_trace_if #(.TS_WIDTH(32), .ADDR_WIDTH(16), .PAYLOAD_WIDTH(64)) bus ();
  gouram_trace_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus), .cfg_mode(cfg_mode), .cfg_start_addr(cfg_start_addr),
    .cfg_stop_addr(cfg_stop_addr), .arm(arm), .stop(stop), .clear_lock(clear_lock),
    .trace_capture_enable(trace_capture_enable), .lock(lock), .overflow(overflow),
    .drop_count(drop_count), .counter_o(counter_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) exp_cnt <= rst ? '1 : exp_cnt + 1;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] a, input logic cap);
    logic [63:0] p;
    p = {$urandom, $urandom};
    bus.rec_valid = 1;
    bus.rec_addr = a;
    bus.rec_payload = p;
    if (cap) sb.push_back({exp_cnt, a, p});
    step(1);
    bus.rec_valid = 0;
  endtask
  task automatic do_arm(input logic [1:0] m);
    cfg_mode = m;
    arm = 1;
    step(1);
    arm = 0;
  endtask
  always @(negedge clk) begin
    logic [111:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("unexpected_pop", {bus.out_ts, bus.out_addr}, 0);
      else begin
        e = sb.pop_front();
        check("out_ts", bus.out_ts, e[111:80]);
        check("out_addr", bus.out_addr, e[79:64]);
        check("out_payload", bus.out_payload, e[63:0]);
      end
    end
  end
  initial begin
    bus.rec_valid = 0;
    bus.rec_addr = 0;
    bus.rec_payload = 0;
    bus.out_ready = 1;
    step(3);
    check("rst_counter", counter_o, 32'hffff_ffff);
    rst = 0;
    step(5);
    check("idle_counter", counter_o, 4);
    check("idle_counter_model", counter_o, exp_cnt);
    check("idle_valid", bus.out_valid, 0);
    check("idle_tce", trace_capture_enable, 0);
    check("idle_lock", lock, 0);
    check("idle_out_ts", bus.out_ts, 0);
    // mode 0 free-run
    do_arm(0);
    check("m0_tce", trace_capture_enable, 1);
    for (int i = 0; i < 4; i++) send(16'h10 + 16'(i), 1);
    step(3);
    check("m0_drained", sb.size(), 0);
    check("m0_drop", drop_count, 0);
    stop = 1;
    step(1);
    stop = 0;
    check("m0_stop_tce", trace_capture_enable, 0);
    // mode 1 window
    cfg_start_addr = 16'h20;
    cfg_stop_addr = 16'h30;
    do_arm(1);
    check("m1_armed_tce", trace_capture_enable, 0);
    send(16'h08, 0);
    check("m1_still_armed", trace_capture_enable, 0);
    send(16'h20, 1);
    check("m1_capture_tce", trace_capture_enable, 1);
    send(16'h24, 1);
    send(16'h30, 1);
    check("m1_stopped", trace_capture_enable, 0);
    send(16'h34, 0);
    step(3);
    check("m1_drained", sb.size(), 0);
    // window with identical start and stop address
    cfg_start_addr = 16'h50;
    cfg_stop_addr = 16'h50;
    do_arm(1);
    send(16'h50, 1);
    check("eq_start_keeps", trace_capture_enable, 1);
    send(16'h50, 1);
    check("eq_second_stops", trace_capture_enable, 0);
    step(3);
    check("eq_drained", sb.size(), 0);
    // mode 2 stop-on-repeat
    do_arm(2);
    for (int i = 0; i < 3; i++) begin
      send(16'h40, 1);
      check("m2_no_lock", lock, 0);
    end
    send(16'h40, 1);
    check("m2_lock", lock, 1);
    check("m2_lock_tce", trace_capture_enable, 0);
    send(16'h44, 0);
    stop = 1;
    step(1);
    stop = 0;
    check("m2_stop_ignored", lock, 1);
    clear_lock = 1;
    step(1);
    clear_lock = 0;
    check("m2_cleared", lock, 0);
    check("m2_idle_tce", trace_capture_enable, 0);
    step(3);
    check("m2_drained", sb.size(), 0);
    // overflow
    bus.out_ready = 0;
    do_arm(0);
    for (int i = 0; i < 11; i++) send(16'h100 + 16'(i), i < 8);
    check("ovf_drop", drop_count, 3);
    check("ovf_flag", overflow, 1);
    check("ovf_valid", bus.out_valid, 1);
    bus.out_ready = 1;
    step(8);
    check("ovf_empty", bus.out_valid, 0);
    check("ovf_drained", sb.size(), 0);
    // full FIFO with simultaneous push and pop
    bus.out_ready = 0;
    for (int i = 0; i < 8; i++) send(16'h200 + 16'(i), 1);
    bus.out_ready = 1;
    send(16'h2ff, 1);
    bus.out_ready = 0;
    check("full_pop_drop", drop_count, 3);
    check("full_pop_level", sb.size(), 8);
    check("full_pop_valid", bus.out_valid, 1);
    // reset mid-session
    rst = 1;
    step(1);
    sb.delete();
    check("rst_valid", bus.out_valid, 0);
    check("rst_tce", trace_capture_enable, 0);
    check("rst_lock", lock, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_count, 0);
    check("rst_cnt", counter_o, 32'hffff_ffff);
    check("rst_out", {bus.out_ts, bus.out_addr, bus.out_payload}, 0);
    rst = 0;
    step(2);
    check("post_rst_cnt", counter_o, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
